// File: rtl/router_fsm_nch.sv
// Packet controller for one input port feeding NUM_CH output FIFOs: header decode,
// payload/parity load, full-FIFO stall, bounded wait for an empty FIFO, and packet drop.
module router_fsm_nch #(
  parameter int NUM_CH   = 3,
  parameter int ADDR_W   = 2,
  parameter int WAIT_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              pkt_valid,
  input  logic              fifo_full,
  input  logic [NUM_CH-1:0] fifo_empty,
  input  logic [NUM_CH-1:0] soft_rst,
  input  logic              parity_done,
  input  logic              low_packet_valid,
  output logic              write_enb_reg,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              rst_int_reg,
  output logic              busy,
  output logic              drop_state,
  output logic              wait_timeout,
  output logic [ADDR_W-1:0] cur_addr
);

  localparam int CNT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam int NSEL  = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]  CH_LIM   = (ADDR_W + 1)'(NUM_CH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WAIT_MAX);
  localparam bit               TO_EN    = (WAIT_MAX != 0);

  typedef enum logic [3:0] {
    S_DA   = 4'd0,
    S_LFD  = 4'd1,
    S_LD   = 4'd2,
    S_FFS  = 4'd3,
    S_LAF  = 4'd4,
    S_LP   = 4'd5,
    S_CPE  = 4'd6,
    S_WTE  = 4'd7,
    S_DROP = 4'd8
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic              r_wait_timeout;
  logic [NSEL-1:0]   w_empty_vec;
  logic [NSEL-1:0]   w_soft_vec;
  logic              w_addr_bad;
  logic              w_timeout_hit;

  // Flags padded to the full address space so nonexistent channels read as 0.
  always_comb begin
    w_empty_vec = '0;
    w_soft_vec  = '0;
    w_empty_vec[NUM_CH-1:0] = fifo_empty;
    w_soft_vec[NUM_CH-1:0]  = soft_rst;
  end

  assign w_addr_bad    = ({1'b0, data_in} >= CH_LIM);
  assign w_timeout_hit = TO_EN && (r_wait_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_DA;
      r_cur_addr     <= '0;
      r_wait_cnt     <= '0;
      r_wait_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DA && pkt_valid) r_cur_addr <= data_in;
      if (r_state != S_WTE)             r_wait_cnt <= '0;
      else if (r_wait_cnt != CNT_MAX)   r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      r_wait_timeout <= (r_state == S_WTE) && (w_next == S_DROP);
    end
  end

  always_comb begin
    w_next = r_state;
    if (r_state != S_DA && w_soft_vec[r_cur_addr]) begin
      w_next = S_DA;
    end else begin
      case (r_state)
        S_DA: begin
          if (pkt_valid) begin
            if (w_addr_bad)                w_next = S_DROP;
            else if (w_empty_vec[data_in]) w_next = S_LFD;
            else                           w_next = S_WTE;
          end
        end
        S_LFD: w_next = S_LD;
        S_LD: begin
          if (fifo_full)       w_next = S_FFS;
          else if (!pkt_valid) w_next = S_LP;
        end
        S_FFS: if (!fifo_full) w_next = S_LAF;
        S_LAF: begin
          if (parity_done)           w_next = S_DA;
          else if (low_packet_valid) w_next = S_LP;
          else                       w_next = S_LD;
        end
        S_LP:  w_next = S_CPE;
        S_CPE: w_next = fifo_full ? S_FFS : S_DA;
        // An emptied FIFO takes priority over a timeout in the same cycle.
        S_WTE: begin
          if (w_empty_vec[r_cur_addr]) w_next = S_LFD;
          else if (w_timeout_hit)      w_next = S_DROP;
        end
        S_DROP: if (!pkt_valid) w_next = S_DA;
        default: w_next = S_DA;
      endcase
    end
  end

  // Input handshake: busy=1 asks the input port to hold its byte; a byte is taken
  // on every cycle with pkt_valid=1 and busy=0 (in DROP it is taken and discarded).
  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    rst_int_reg   = 1'b0;
    drop_state    = 1'b0;
    busy          = 1'b0;
    write_enb_reg = 1'b0;
    case (r_state)
      S_DA:   detect_add = 1'b1;
      S_LFD:  begin lfd_state = 1'b1; busy = 1'b1; end
      S_LD:   begin ld_state = 1'b1; write_enb_reg = 1'b1; end
      S_FFS:  begin full_state = 1'b1; busy = 1'b1; end
      S_LAF:  begin laf_state = 1'b1; write_enb_reg = 1'b1; busy = 1'b1; end
      S_LP:   begin write_enb_reg = 1'b1; busy = 1'b1; end
      S_CPE:  begin rst_int_reg = 1'b1; busy = 1'b1; end
      S_WTE:  busy = 1'b1;
      S_DROP: drop_state = 1'b1;
      default: detect_add = 1'b1;
    endcase
  end

  assign wait_timeout = r_wait_timeout;
  assign cur_addr     = r_cur_addr;

endmodule

// File: tb/tb_router_fsm_nch.sv
// Bench for router_fsm_nch: directed packet scenarios with literal expectations,
// then randomized traffic checked every cycle against a packet-phase model.
module tb_router_fsm_nch;

  localparam int NUM_CH   = 3;
  localparam int ADDR_W   = 2;
  localparam int WAIT_MAX = 16;

  // Output vector: {detect,lfd,ld,laf,full,rst_int,drop,busy,write_enb}
  localparam logic [8:0] O_DA   = 9'b1000000_00;
  localparam logic [8:0] O_LFD  = 9'b0100000_10;
  localparam logic [8:0] O_LD   = 9'b0010000_01;
  localparam logic [8:0] O_LAF  = 9'b0001000_11;
  localparam logic [8:0] O_FFS  = 9'b0000100_10;
  localparam logic [8:0] O_CPE  = 9'b0000010_10;
  localparam logic [8:0] O_DROP = 9'b0000001_00;
  localparam logic [8:0] O_WTE  = 9'b0000000_10;
  localparam logic [8:0] O_LP   = 9'b0000000_11;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst;
  logic [ADDR_W-1:0] data_in;
  logic pkt_valid, fifo_full, parity_done, low_packet_valid;
  logic [NUM_CH-1:0] fifo_empty, soft_rst;
  logic write_enb_reg, detect_add, lfd_state, ld_state, laf_state, full_state;
  logic rst_int_reg, busy, drop_state, wait_timeout;
  logic [ADDR_W-1:0] cur_addr;

  always #5 clk = ~clk;

  router_fsm_nch #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .pkt_valid(pkt_valid),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_rst(soft_rst),
    .parity_done(parity_done), .low_packet_valid(low_packet_valid),
    .write_enb_reg(write_enb_reg), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .busy(busy), .drop_state(drop_state),
    .wait_timeout(wait_timeout), .cur_addr(cur_addr)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  function automatic logic [8:0] dut_outs();
    return {detect_add, lfd_state, ld_state, laf_state, full_state,
            rst_int_reg, drop_state, busy, write_enb_reg};
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- packet-phase reference model ----------------
  typedef enum int {P_IDLE, P_HEAD, P_BODY, P_STALL, P_RESUME,
                    P_PARITY, P_CHECK, P_WAIT, P_DISCARD} phase_t;
  phase_t m_ph;
  logic [ADDR_W-1:0] m_addr;
  logic m_tout;
  int cyc_no, m_wait_start;

  function automatic bit ch_bit(input logic [NUM_CH-1:0] v, input int a);
    if (a < NUM_CH) return v[a];
    return 1'b0;
  endfunction

  function automatic logic [8:0] phase_outs(input phase_t ph);
    case (ph)
      P_IDLE:    return O_DA;
      P_HEAD:    return O_LFD;
      P_BODY:    return O_LD;
      P_STALL:   return O_FFS;
      P_RESUME:  return O_LAF;
      P_PARITY:  return O_LP;
      P_CHECK:   return O_CPE;
      P_WAIT:    return O_WTE;
      P_DISCARD: return O_DROP;
      default:   return 9'h0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph <= P_IDLE; m_addr <= '0; m_tout <= 1'b0; cyc_no <= 0; m_wait_start <= 0;
    end else begin
      cyc_no <= cyc_no + 1;
      m_tout <= 1'b0;
      if (m_ph != P_IDLE && ch_bit(soft_rst, int'(m_addr))) m_ph <= P_IDLE;
      else case (m_ph)
        P_IDLE: if (pkt_valid) begin
          m_addr <= data_in;
          if (int'(data_in) >= NUM_CH) m_ph <= P_DISCARD;
          else if (ch_bit(fifo_empty, int'(data_in))) m_ph <= P_HEAD;
          else begin m_ph <= P_WAIT; m_wait_start <= cyc_no; end
        end
        P_HEAD:   m_ph <= P_BODY;
        P_BODY:   if (fifo_full) m_ph <= P_STALL; else if (!pkt_valid) m_ph <= P_PARITY;
        P_STALL:  if (!fifo_full) m_ph <= P_RESUME;
        P_RESUME: m_ph <= parity_done ? P_IDLE : (low_packet_valid ? P_PARITY : P_BODY);
        P_PARITY: m_ph <= P_CHECK;
        P_CHECK:  m_ph <= fifo_full ? P_STALL : P_IDLE;
        // cyc_no - m_wait_start = number of wait cycles spent, including this one
        P_WAIT: begin
          if (ch_bit(fifo_empty, int'(m_addr))) m_ph <= P_HEAD;
          else if (WAIT_MAX != 0 && cyc_no - m_wait_start == WAIT_MAX) begin
            m_ph <= P_DISCARD; m_tout <= 1'b1;
          end
        end
        P_DISCARD: if (!pkt_valid) m_ph <= P_IDLE;
        default:   m_ph <= P_IDLE;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("model_outs", 32'(dut_outs()), 32'(phase_outs(m_ph)));
      cmp("model_cur_addr", 32'(cur_addr), 32'(m_addr));
      cmp("model_wait_timeout", 32'(wait_timeout), 32'(m_tout));
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic pv, input logic [ADDR_W-1:0] din,
                      input logic [NUM_CH-1:0] emp, input logic ff,
                      input logic [NUM_CH-1:0] sr, input logic pd, input logic lpv);
    #1;
    pkt_valid = pv; data_in = din; fifo_empty = emp; fifo_full = ff;
    soft_rst = sr; parity_done = pd; low_packet_valid = lpv;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; pkt_valid = 0; data_in = '0; fifo_empty = '0; fifo_full = 0;
    soft_rst = '0; parity_done = 0; low_packet_valid = 0;
    repeat (2) @(negedge clk);
    cmp("in_reset_outs", 32'(dut_outs()), 32'(O_DA));
    cmp("in_reset_timeout", 32'(wait_timeout), 32'd0);
    #1 rst = 1'b0; chk_en = 1'b1;
    step(0, 2'd0, 3'b000, 0, 3'b000, 0, 0);
    cmp("reset_outs", 32'(dut_outs()), 32'(O_DA));
    cmp("reset_cur_addr", 32'(cur_addr), 32'd0);

    // Normal packet to channel 1
    step(1, 2'd1, 3'b010, 0, 3'b000, 0, 0); cmp("pkt1_lfd", 32'(dut_outs()), 32'(O_LFD));
    cmp("pkt1_cur_addr", 32'(cur_addr), 32'd1);
    step(1, 2'd1, 3'b010, 0, 3'b000, 0, 0); cmp("pkt1_ld0", 32'(dut_outs()), 32'(O_LD));
    step(1, 2'd1, 3'b010, 0, 3'b000, 0, 0); cmp("pkt1_ld1", 32'(dut_outs()), 32'(O_LD));
    step(1, 2'd1, 3'b010, 0, 3'b000, 0, 0); cmp("pkt1_ld2", 32'(dut_outs()), 32'(O_LD));
    step(0, 2'd1, 3'b010, 0, 3'b000, 0, 0); cmp("pkt1_lp", 32'(dut_outs()), 32'(O_LP));
    step(0, 2'd1, 3'b010, 0, 3'b000, 0, 0); cmp("pkt1_cpe", 32'(dut_outs()), 32'(O_CPE));
    step(0, 2'd1, 3'b010, 0, 3'b000, 0, 0); cmp("pkt1_da", 32'(dut_outs()), 32'(O_DA));

    // Full stall then low_packet_valid exit
    step(1, 2'd1, 3'b010, 0, 3'b000, 0, 0);
    step(1, 2'd1, 3'b010, 0, 3'b000, 0, 0); cmp("ffs_pre_ld", 32'(dut_outs()), 32'(O_LD));
    for (int i = 0; i < 3; i++) begin
      step(1, 2'd1, 3'b010, 1, 3'b000, 0, 0); cmp("ffs_stall", 32'(dut_outs()), 32'(O_FFS));
    end
    step(0, 2'd1, 3'b010, 0, 3'b000, 0, 1); cmp("ffs_laf", 32'(dut_outs()), 32'(O_LAF));
    step(0, 2'd1, 3'b010, 0, 3'b000, 0, 1); cmp("ffs_lp", 32'(dut_outs()), 32'(O_LP));
    step(0, 2'd1, 3'b010, 0, 3'b000, 0, 0); cmp("ffs_cpe", 32'(dut_outs()), 32'(O_CPE));
    step(0, 2'd1, 3'b010, 0, 3'b000, 0, 0); cmp("ffs_da", 32'(dut_outs()), 32'(O_DA));

    // Wait-till-empty timeout on channel 2
    for (int i = 0; i < WAIT_MAX; i++) begin
      step(1, 2'd2, 3'b000, 0, 3'b000, 0, 0); cmp("wte_wait", 32'(dut_outs()), 32'(O_WTE));
      cmp("wte_no_pulse", 32'(wait_timeout), 32'd0);
    end
    step(1, 2'd2, 3'b000, 0, 3'b000, 0, 0); cmp("wte_drop", 32'(dut_outs()), 32'(O_DROP));
    cmp("wte_pulse", 32'(wait_timeout), 32'd1);
    cmp("wte_cur_addr", 32'(cur_addr), 32'd2);
    step(1, 2'd2, 3'b000, 0, 3'b000, 0, 0); cmp("wte_pulse_end", 32'(wait_timeout), 32'd0);
    step(0, 2'd2, 3'b000, 0, 3'b000, 0, 0); cmp("wte_back_da", 32'(dut_outs()), 32'(O_DA));

    // Nonexistent channel 3
    step(1, 2'd3, 3'b111, 0, 3'b000, 0, 0); cmp("bad_addr_drop", 32'(dut_outs()), 32'(O_DROP));
    step(1, 2'd3, 3'b111, 0, 3'b000, 0, 0); cmp("bad_addr_hold", 32'(dut_outs()), 32'(O_DROP));
    step(0, 2'd3, 3'b111, 0, 3'b000, 0, 0); cmp("bad_addr_da", 32'(dut_outs()), 32'(O_DA));

    // Soft reset on own channel vs other channel, then async reset in FFS
    step(1, 2'd0, 3'b001, 0, 3'b000, 0, 0);
    step(1, 2'd0, 3'b001, 0, 3'b000, 0, 0); cmp("srst_ld", 32'(dut_outs()), 32'(O_LD));
    step(1, 2'd0, 3'b001, 0, 3'b001, 0, 0); cmp("srst_own", 32'(dut_outs()), 32'(O_DA));
    step(1, 2'd0, 3'b001, 0, 3'b000, 0, 0);
    step(1, 2'd0, 3'b001, 0, 3'b000, 0, 0);
    step(1, 2'd0, 3'b001, 0, 3'b100, 0, 0); cmp("srst_other", 32'(dut_outs()), 32'(O_LD));
    step(1, 2'd0, 3'b001, 1, 3'b000, 0, 0); cmp("arst_pre_ffs", 32'(dut_outs()), 32'(O_FFS));
    #1 rst = 1'b1;
    #1 cmp("arst_immediate", 32'(dut_outs()), 32'(O_DA));
    @(negedge clk);
    #1 rst = 1'b0;
    step(0, 2'd0, 3'b000, 0, 3'b000, 0, 0); cmp("arst_after", 32'(dut_outs()), 32'(O_DA));

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(7) != 0), ADDR_W'($urandom_range(3)),
           {($urandom_range(7) == 0), ($urandom_range(7) == 0), ($urandom_range(7) == 0)},
           ($urandom_range(5) == 0),
           {($urandom_range(31) == 0), ($urandom_range(31) == 0), ($urandom_range(31) == 0)},
           ($urandom_range(3) == 0), ($urandom_range(1) == 1));
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/router_fsm_nch.md
Name: router_fsm_nch

Overview:
Parametrised successor to the 1x3 router controller FSM. It sequences header decode, first-data load, payload load, FIFO-full stall, parity load and parity check for one input port feeding NUM_CH output FIFOs. New capabilities over the 1x3 FSM:
- drops packets addressed to a nonexistent channel;
- bounds the wait-till-empty stall with a programmable timeout;
- latches the destination address for the rest of the packet.

Parameters:
NUM_CH, 3, number of output channels/FIFOs (2..2**ADDR_W)
ADDR_W, 2, header address field width (data_in[ADDR_W-1:0])
WAIT_MAX, 16, maximum cycles spent in WAIT_TILL_EMPTY before drop; 0 = no timeout

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
data_in  input  ADDR_W  header address bits of current input byte
pkt_valid  input  1  input packet valid
fifo_full  input  1  full flag of currently selected FIFO
fifo_empty  input  NUM_CH  per-channel FIFO empty flags
soft_rst  input  NUM_CH  per-channel soft reset (read-timeout) from sync block
parity_done  input  1  parity byte already loaded
low_packet_valid  input  1  pkt_valid fell while stalled on full
write_enb_reg  output  1  register block write enable
detect_add  output  1  header decode phase
lfd_state  output  1  load-first-data state
ld_state  output  1  load-data state
laf_state  output  1  load-after-full state
full_state  output  1  FIFO-full stall state
rst_int_reg  output  1  clear internal parity regs (check-parity state)
busy  output  1  input port must hold data
drop_state  output  1  packet being discarded
wait_timeout  output  1  one-cycle pulse on wait timeout
cur_addr  output  ADDR_W  latched destination of current packet

Behaviour:
- Moore outputs, decoded from the state register only. cur_addr and the wait counter are registered.
- rst high (async): state=DECODE_ADDRESS, cur_addr=0, wait_cnt=0, wait_timeout=0. Output values under reset: detect_add=1, every other output 0.
- Next-state priority: rst > soft_rst[cur_addr] > normal transitions.
- Soft reset: when soft_rst[cur_addr]=1 in any state except DECODE_ADDRESS, the next state is DECODE_ADDRESS.
- DECODE_ADDRESS (DA): detect_add=1, busy=0.
  - pkt_valid=1 latches cur_addr<=data_in.
  - data_in>=NUM_CH -> DROP.
  - fifo_empty[data_in]=1 -> LFD.
  - otherwise -> WTE.
  - pkt_valid=0 -> stay in DA.
- LFD: lfd_state=1, busy=1; unconditionally -> LD.
- LD: ld_state=1, write_enb_reg=1, busy=0.
  - fifo_full=1 -> FFS.
  - else pkt_valid=0 -> LP.
  - else stay in LD.
- FFS: full_state=1, busy=1; fifo_full=0 -> LAF.
- LAF: laf_state=1, write_enb_reg=1, busy=1.
  - parity_done=1 -> DA.
  - else low_packet_valid=1 -> LP.
  - else -> LD.
- LP (load parity): write_enb_reg=1, busy=1; unconditionally -> CPE.
- CPE: rst_int_reg=1, busy=1; fifo_full=1 -> FFS, else -> DA.
- WTE: busy=1, wait_cnt increments each cycle in WTE and is cleared to 0 on entry.
  - fifo_empty[cur_addr]=1 -> LFD. Empty wins over a simultaneous timeout.
  - else WAIT_MAX!=0 and wait_cnt==WAIT_MAX-1 -> DROP, with wait_timeout=1 for exactly the first DROP cycle.
  - So WTE lasts at most WAIT_MAX cycles.
  - wait_cnt width is clog2(WAIT_MAX+1); it never wraps.
- DROP: drop_state=1, busy=0, write_enb_reg=0.
  - Input bytes are accepted and discarded.
  - pkt_valid=0 -> DA; the parity byte is consumed that cycle.
- Exactly one of detect_add/lfd_state/ld_state/laf_state/full_state/rst_int_reg/drop_state is high in DA/LFD/LD/LAF/FFS/CPE/DROP. In WTE and LP, all seven are low.
- Illegal state encodings -> DA.

Test Plan:
- rst=1 for 2 cycles, then release -> detect_add=1, busy=0, all other outputs 0, cur_addr=0.
- pkt_valid=1, data_in=1, fifo_empty=3'b010, fifo_full=0, hold 4 cycles, then pkt_valid=0 -> state sequence DA,LFD,LD,LD,LD,LP,CPE,DA. write_enb_reg high in LD/LP. rst_int_reg high 1 cycle. cur_addr=1.
- In LD raise fifo_full 3 cycles, then drop it with parity_done=0, low_packet_valid=1 -> FFS x3 with busy=1, then LAF, LP, CPE, DA.
- data_in=2, fifo_empty=3'b000 held, WAIT_MAX=16 -> busy=1 for 16 WTE cycles, then DROP with wait_timeout pulse of 1 cycle. After pkt_valid=0 -> DA.
- NUM_CH=3, data_in=3, pkt_valid=1 -> DROP the next cycle with busy=0, write_enb_reg never asserted. pkt_valid=0 -> DA.
- data_in=0 packet in LD, assert soft_rst=3'b001 1 cycle -> DA next cycle. soft_rst[2]=1 in the same situation -> no effect. Async rst mid-FFS -> DA immediately.
